// File: rtl/pulse_echo_ctrl_pkg.sv
// Shared types and width helper for the pulse/echo time-of-flight sequencer.
package pulse_echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    BLANK,
    LISTEN,
    REPORT
  } state_t;

  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/pulse_echo_ctrl_echo_accum.sv
// Sums per-shot echo counts and presents the truncated average for the batch.
module echo_accum
#(
  parameter int N_SHOTS = 4,
  parameter int CNT_W   = 7
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] sum_avg
);

  localparam int SH    = $clog2(N_SHOTS);
  localparam int ACC_W = SH + CNT_W;

  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sum_next;

  assign sum_next = sum + ACC_W'(value);

  always_ff @(posedge clk) begin
    if (!rst_n)
      sum <= '0;
    else if (clear)
      sum <= '0;
    else if (add)
      sum <= sum_next;
  end

  // Include the value being added this cycle so the final shot is counted
  assign sum_avg = CNT_W'((add ? sum_next : sum) >> SH);

endmodule

// File: rtl/pulse_echo_ctrl.sv
// Time-of-flight sequencer: fire, blank, listen for the echo, report count or timeout.
// Optional macro PULSE_ECHO_AVG_EN averages N_SHOTS back-to-back shots per start.
module pulse_echo_ctrl
  import pulse_echo_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int BLANK_LEN = 8,
  parameter int MAX_WAIT  = 100,
`ifdef PULSE_ECHO_AVG_EN
  parameter int N_SHOTS   = 4,
`endif
  localparam int CNT_W    = cnt_width(MAX_WAIT)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             echo_edge,
  output logic             tx_pulse,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_data,
  output logic             result_timeout
);

  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(PULSE_LEN + BLANK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             counting;
  logic             fire_entry;

`ifdef PULSE_ECHO_AVG_EN
  localparam int SHOT_W = $clog2(N_SHOTS) + 1;

  logic [SHOT_W-1:0] shot_cnt;
  logic              last_shot;
  logic [CNT_W-1:0]  avg_data;

  assign last_shot = (shot_cnt == SHOT_W'(N_SHOTS - 1));

  echo_accum #(
    .N_SHOTS (N_SHOTS),
    .CNT_W   (CNT_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE && start),
    .add     (state == LISTEN && echo_edge),
    .value   (cnt),
    .sum_avg (avg_data)
  );
`endif

  assign counting   = (state == FIRE) || (state == BLANK) || (state == LISTEN);
  assign fire_entry = (next_state == FIRE) && (state != FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      result_data    <= '0;
      result_timeout <= 1'b0;
`ifdef PULSE_ECHO_AVG_EN
      shot_cnt       <= '0;
`endif
    end else begin
      state <= next_state;
      if (fire_entry)
        cnt <= '0;
      else if (counting && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (state == LISTEN) begin
        if (echo_edge) begin
`ifdef PULSE_ECHO_AVG_EN
          shot_cnt <= shot_cnt + 1'b1;
          if (last_shot) begin
            result_data    <= avg_data;
            result_timeout <= 1'b0;
          end
`else
          result_data    <= cnt;
          result_timeout <= 1'b0;
`endif
        end else if (cnt == CNT_MAX) begin
          result_data    <= '0;
          result_timeout <= 1'b1;
        end
      end
`ifdef PULSE_ECHO_AVG_EN
      if (state == IDLE && start)
        shot_cnt <= '0;
`endif
    end
  end

  // An echo on the final budget cycle still counts as a hit
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = FIRE;
      FIRE:   if (cnt == PULSE_END) next_state = (BLANK_LEN == 0) ? LISTEN : BLANK;
      BLANK:  if (cnt == BLANK_END) next_state = LISTEN;
      LISTEN: begin
        if (echo_edge) begin
`ifdef PULSE_ECHO_AVG_EN
          next_state = last_shot ? REPORT : FIRE;
`else
          next_state = REPORT;
`endif
        end else if (cnt == CNT_MAX) begin
          next_state = REPORT;
        end
      end
      REPORT: if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_pulse     = (state == FIRE);
    busy         = (state != IDLE);
    result_valid = (state == REPORT);
  end

endmodule

// File: tb/tb_pulse_echo_ctrl.sv
// Self-checking bench for pulse_echo_ctrl against a shot-level reference model.
// Define PULSE_ECHO_AVG_EN to exercise the multi-shot averaging build instead.
module tb_pulse_echo_ctrl;

  localparam int PULSE_LEN = 4;
  localparam int BLANK_LEN = 8;
  localparam int MAX_WAIT  = 100;
  localparam int N_SHOTS   = 4;
  localparam int CNT_W     = $clog2(MAX_WAIT + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             echo_edge;
  logic             result_ready;
  logic             tx_pulse;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result_data;
  logic             result_timeout;

  int checks = 0;
  int errors = 0;
  int echo_q[$];

  pulse_echo_ctrl #(
    .PULSE_LEN (PULSE_LEN),
    .BLANK_LEN (BLANK_LEN),
`ifdef PULSE_ECHO_AVG_EN
    .N_SHOTS   (N_SHOTS),
`endif
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .echo_edge      (echo_edge),
    .tx_pulse       (tx_pulse),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_data    (result_data),
    .result_timeout (result_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit echo_at(input int c);
    foreach (echo_q[i]) if (echo_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Earliest echo inside the listening window, or -1 for a timeout
  function automatic int first_hit();
    int best = -1;
    foreach (echo_q[i])
      if (echo_q[i] >= PULSE_LEN + BLANK_LEN && echo_q[i] <= MAX_WAIT - 1)
        if (best < 0 || echo_q[i] < best) best = echo_q[i];
    return best;
  endfunction

  // One single-shot measurement: cycle t after the start edge carries counter t-1
  task automatic applyStimulus(input int ready_delay, input bit repulse);
    int hit;
    int valid_t;
    int exp_data;
    bit exp_to;
    hit      = first_hit();
    exp_to   = (hit < 0);
    exp_data = exp_to ? 0 : hit;
    valid_t  = exp_to ? MAX_WAIT + 1 : hit + 2;
    @(negedge clk);
    start = 1'b1; echo_edge = 1'b0; result_ready = 1'b0;
    for (int t = 1; t <= valid_t; t++) begin
      @(negedge clk);
      checkOutput("tx_pulse", {31'd0, tx_pulse}, {31'd0, t <= PULSE_LEN});
      checkOutput("valid_timing", {31'd0, result_valid}, {31'd0, t == valid_t});
      checkOutput("busy_shot", {31'd0, busy}, 32'd1);
      start     = repulse && (t % 5 == 0);
      echo_edge = echo_at(t - 1);
    end
    checkOutput("data", 32'(result_data), 32'(exp_data));
    checkOutput("timeout", {31'd0, result_timeout}, {31'd0, exp_to});
    result_ready = (ready_delay == 0);
    for (int d = 1; d <= ready_delay; d++) begin
      @(negedge clk);
      checkOutput("valid_held", {31'd0, result_valid}, 32'd1);
      checkOutput("data_held", 32'(result_data), 32'(exp_data));
      checkOutput("timeout_held", {31'd0, result_timeout}, {31'd0, exp_to});
      start        = repulse;
      echo_edge    = 1'b0;
      result_ready = (d == ready_delay);
    end
    @(negedge clk);
    checkOutput("valid_after_xfer", {31'd0, result_valid}, 32'd0);
    checkOutput("busy_after_xfer", {31'd0, busy}, 32'd0);
    start = 1'b0; result_ready = 1'b0; echo_edge = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_tx", {31'd0, tx_pulse}, 32'd0);
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

`ifdef PULSE_ECHO_AVG_EN
  // One batch; tgt[s] is the echo counter for shot s, or -1 for no echo
  task automatic applyBatch(input int tgt[N_SHOTS]);
    int shot = -1;
    int cyc = 0;
    int pulses = 0;
    int exp_pulses = N_SHOTS;
    int sum = 0;
    bit exp_to = 1'b0;
    bit prev_tx = 1'b0;
    for (int s = 0; s < N_SHOTS; s++) begin
      if (!exp_to && tgt[s] < 0) begin
        exp_to = 1'b1;
        exp_pulses = s + 1;
      end
      sum += tgt[s];
    end
    @(negedge clk);
    start = 1'b1; result_ready = 1'b0; echo_edge = 1'b0;
    for (int n = 0; n < 1000 && !result_valid; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx_pulse && !prev_tx) begin
        shot++; cyc = 0; pulses++;
      end else begin
        cyc++;
      end
      prev_tx   = tx_pulse;
      echo_edge = (shot >= 0 && shot < N_SHOTS) ? (tgt[shot] >= 0 && cyc == tgt[shot]) : 1'b0;
      if (result_valid) echo_edge = 1'b0;
    end
    checkOutput("batch_valid", {31'd0, result_valid}, 32'd1);
    checkOutput("batch_pulses", 32'(pulses), 32'(exp_pulses));
    checkOutput("batch_timeout", {31'd0, result_timeout}, {31'd0, exp_to});
    checkOutput("batch_data", 32'(result_data), exp_to ? 32'd0 : 32'(sum / N_SHOTS));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("batch_done_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("batch_done_busy", {31'd0, busy}, 32'd0);
  endtask
`endif

  initial begin
    int a[N_SHOTS];
    rst_n = 1'b0; start = 1'b0; echo_edge = 1'b0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx", {31'd0, tx_pulse}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_data", 32'(result_data), 32'd0);
    checkOutput("rst_timeout", {31'd0, result_timeout}, 32'd0);
    rst_n = 1'b1;

`ifndef PULSE_ECHO_AVG_EN
    $display("[TB] single-shot directed cases");
    echo_q = {30};        applyStimulus(0, 1'b0);
    echo_q.delete();      applyStimulus(0, 1'b0);
    echo_q = {2, 7, 45};  applyStimulus(1, 1'b0);
    echo_q = {11, 12};    applyStimulus(0, 1'b0);
    echo_q = {99};        applyStimulus(2, 1'b0);
    echo_q = {40};        applyStimulus(10, 1'b1);

    $display("[TB] reset during LISTEN");
    echo_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx", {31'd0, tx_pulse}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("abort_data", 32'(result_data), 32'd0);
    checkOutput("abort_timeout", {31'd0, result_timeout}, 32'd0);
    rst_n = 1'b1; echo_edge = 1'b1;
    @(negedge clk); echo_edge = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("abort_no_result", {31'd0, result_valid}, 32'd0);
      checkOutput("abort_idle", {31'd0, busy}, 32'd0);
    end

    $display("[TB] randomized shots");
    for (int k = 0; k < 12; k++) begin
      echo_q.delete();
      repeat ($urandom_range(0, 3)) echo_q.push_back(int'($urandom_range(0, MAX_WAIT + 5)));
      applyStimulus(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end
`else
    $display("[TB] averaging batches");
    a = '{20, 22, 24, 26}; applyBatch(a);
    a = '{20, 22, -1, 26}; applyBatch(a);
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < N_SHOTS; s++)
        a[s] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(PULSE_LEN + BLANK_LEN, MAX_WAIT - 1));
      applyBatch(a);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
